// File: rtl/l1_loop_wb_responder.sv
// Wishbone responder for the L1 trigger loop: staged thresholds, count handshake, scaler reads.
// Acks 1 cycle after request (2 for scaler); THRESH writes stall while an apply sequence is running.
module l1_loop_wb_responder #(
  parameter int unsigned NBEAMS      = 2,
  parameter logic [17:0] THRESH_INIT = 18'd4000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [21:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              count_start_o,
  input  logic              count_done_i,
  output logic [5:0]        scal_idx_o,
  input  logic [31:0]       scal_dat_i,
  output logic [17:0]       thresh_o,
  output logic [NBEAMS-1:0] thresh_ce_o,
  output logic              update_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {AP_IDLE, AP_PREP, AP_LOAD, AP_UPDATE} ap_state_t;

  localparam logic [1:0] RG_CTRL   = 2'd0;
  localparam logic [1:0] RG_THRESH = 2'd1;
  localparam logic [1:0] RG_SCALER = 2'd2;

  ap_state_t   ap_state_q, ap_state_d;
  logic [5:0]  beam_q, beam_d;
  logic        pending_q, pending_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        scal_pend_q, scal_pend_d;
  logic        scal_ok_q, scal_ok_d;
  logic [5:0]  scal_idx_q, scal_idx_d;
  logic        start_q, start_d;
  logic        apply_q, apply_d;
  logic        finished_q, finished_d;
  logic [17:0] staged_q [NBEAMS];
  logic [17:0] staged_d [NBEAMS];

  logic [1:0]  region;
  logic [5:0]  idx;
  logic        idx_ok;
  logic        req;
  logic        wr_stall;
  logic        accept;
  logic [17:0] thr_rd;
  logic [17:0] thr_ld;
  logic        unused_bits;

  assign region      = wb_adr_i[13:12];
  assign idx         = wb_adr_i[7:2];
  assign idx_ok      = idx < 6'(NBEAMS);
  assign unused_bits = ^{wb_adr_i[21:14], wb_adr_i[11:8], wb_adr_i[1:0], wb_dat_i[31:18]};

  // A request is only new when no ack or scaler fetch is outstanding.
  assign req      = wb_cyc_i & wb_stb_i & ~ack_q & ~scal_pend_q;
  assign wr_stall = wb_we_i & (region == RG_THRESH) & (ap_state_q != AP_IDLE);
  assign accept   = req & ~wr_stall;

  assign wb_ack_o      = ack_q;
  assign wb_dat_o      = dat_q;
  assign count_start_o = start_q;
  assign scal_idx_o    = scal_idx_q;
  assign update_o      = (ap_state_q == AP_UPDATE);
  assign busy_o        = (ap_state_q != AP_IDLE) | pending_q;

  always_comb begin
    thr_rd      = '0;
    thr_ld      = '0;
    thresh_ce_o = '0;
    for (int i = 0; i < NBEAMS; i++) begin
      if (idx == 6'(i)) thr_rd = staged_q[i];
      if (beam_q == 6'(i)) thr_ld = staged_q[i];
      thresh_ce_o[i] = (ap_state_q == AP_LOAD) && (beam_q == 6'(i));
    end
    thresh_o = (ap_state_q == AP_LOAD) ? thr_ld : 18'd0;
  end

  always_comb begin
    ack_d       = 1'b0;
    dat_d       = '0;
    scal_pend_d = 1'b0;
    scal_ok_d   = scal_ok_q;
    scal_idx_d  = scal_idx_q;
    start_d     = 1'b0;
    apply_d     = 1'b0;
    staged_d    = staged_q;
    if (scal_pend_q) begin
      // Second cycle of a scaler read; dropping stb here abandons it.
      if (wb_cyc_i & wb_stb_i) begin
        ack_d = 1'b1;
        dat_d = scal_ok_q ? scal_dat_i : 32'd0;
      end
    end else if (accept) begin
      case (region)
        RG_CTRL: begin
          ack_d = 1'b1;
          if (wb_we_i) begin
            start_d = wb_dat_i[0];
            apply_d = wb_dat_i[1];
          end else begin
            dat_d = {30'd0, busy_o, finished_q};
          end
        end
        RG_THRESH: begin
          ack_d = 1'b1;
          if (wb_we_i) begin
            for (int i = 0; i < NBEAMS; i++)
              if (idx == 6'(i)) staged_d[i] = wb_dat_i[17:0];
          end else begin
            dat_d = idx_ok ? {14'd0, thr_rd} : 32'd0;
          end
        end
        RG_SCALER: begin
          if (wb_we_i) begin
            ack_d = 1'b1;
          end else begin
            scal_pend_d = 1'b1;
            scal_ok_d   = idx_ok;
            scal_idx_d  = idx;
          end
        end
        default: ack_d = 1'b1;
      endcase
    end
  end

  always_comb begin
    finished_d = finished_q;
    if (start_q) finished_d = 1'b0;
    else if (count_done_i) finished_d = 1'b1;
  end

  always_comb begin
    ap_state_d = ap_state_q;
    beam_d     = beam_q;
    pending_d  = pending_q | (apply_q & (ap_state_q != AP_IDLE));
    case (ap_state_q)
      AP_IDLE: begin
        if (apply_q | pending_q) begin
          ap_state_d = AP_PREP;
          pending_d  = 1'b0;
        end
      end
      AP_PREP: begin
        ap_state_d = AP_LOAD;
        beam_d     = '0;
      end
      AP_LOAD: begin
        if (beam_q == 6'(NBEAMS - 1)) ap_state_d = AP_UPDATE;
        else beam_d = beam_q + 6'd1;
      end
      default: ap_state_d = AP_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ap_state_q  <= AP_IDLE;
      beam_q      <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      scal_pend_q <= 1'b0;
      scal_ok_q   <= 1'b0;
      scal_idx_q  <= '0;
      start_q     <= 1'b0;
      apply_q     <= 1'b0;
      finished_q  <= 1'b0;
      for (int i = 0; i < NBEAMS; i++) staged_q[i] <= THRESH_INIT;
    end else begin
      ap_state_q  <= ap_state_d;
      beam_q      <= beam_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      scal_pend_q <= scal_pend_d;
      scal_ok_q   <= scal_ok_d;
      scal_idx_q  <= scal_idx_d;
      start_q     <= start_d;
      apply_q     <= apply_d;
      finished_q  <= finished_d;
      staged_q    <= staged_d;
    end
  end

endmodule

// File: tb/tb_l1_loop_wb_responder.sv
// Self-checking bench for l1_loop_wb_responder: directed timing cases plus randomized register traffic.
module tb_l1_loop_wb_responder;

  localparam int          NB = 2;
  localparam logic [17:0] TI = 18'd4000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cyc, stb, we;
  logic [21:0]   adr;
  logic [31:0]   wdat;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o;
  logic          count_start_o;
  logic          count_done_i;
  logic [5:0]    scal_idx_o;
  logic [31:0]   scal_dat_i;
  logic [17:0]   thresh_o;
  logic [NB-1:0] thresh_ce_o;
  logic          update_o;
  logic          busy_o;

  logic [31:0]   scal_tab [64];
  assign scal_dat_i = scal_tab[scal_idx_o];

  always #5 clk = ~clk;

  l1_loop_wb_responder #(.NBEAMS(NB), .THRESH_INIT(TI)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .count_start_o(count_start_o), .count_done_i(count_done_i), .scal_idx_o(scal_idx_o),
    .scal_dat_i(scal_dat_i), .thresh_o(thresh_o), .thresh_ce_o(thresh_ce_o),
    .update_o(update_o), .busy_o(busy_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Event log of observable output activity, by cycle number.
  int          ce_cyc [$];
  logic [31:0] ce_val [$];
  logic [31:0] ce_thr [$];
  int          upd_cyc [$];
  int          st_cyc [$];
  int          bz_cyc [$];

  always @(negedge clk) begin
    if (|thresh_ce_o) begin
      ce_cyc.push_back(cyc_n);
      ce_val.push_back(32'(thresh_ce_o));
      ce_thr.push_back(32'(thresh_o));
    end
    if (update_o) upd_cyc.push_back(cyc_n);
    if (count_start_o) st_cyc.push_back(cyc_n);
    if (busy_o) bz_cyc.push_back(cyc_n);
  end

  task automatic clear_log();
    ce_cyc.delete(); ce_val.delete(); ce_thr.delete();
    upd_cyc.delete(); st_cyc.delete(); bz_cyc.delete();
  endtask

  // Reference state: staged thresholds by index and the finished flag.
  logic [17:0] m_thr [64];
  logic        m_fin;

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_thr[i] = (i < NB) ? TI : 18'd0;
    m_fin = 1'b0;
  endtask

  function automatic logic [21:0] mk_adr(input logic [1:0] rg, input logic [5:0] ix);
    logic [7:0] hi;
    logic [3:0] mid;
    hi  = 8'($urandom);
    mid = 4'($urandom);
    return {hi, rg, mid, ix, 2'b00};
  endfunction

  task automatic xfer(input logic w, input logic [21:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int ack_cyc, output int lat);
    int start;
    int k;
    logic got;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
    start = cyc_n;
    got = 1'b0; rd = '0; ack_cyc = -1; lat = -1; k = 0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (wb_ack_o) begin
        got = 1'b1; rd = wb_dat_o; ack_cyc = cyc_n; lat = cyc_n - start;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_apply(input string tag, input int a, input int base, input int upd_i);
    for (int i = 0; i < NB; i++) begin
      if (base + i < ce_cyc.size()) begin
        chk({tag, "_ce_cyc"}, 32'(ce_cyc[base + i]), 32'(a + 2 + i));
        chk({tag, "_ce_val"}, ce_val[base + i], 32'(1) << i);
        chk({tag, "_thr"}, ce_thr[base + i], 32'(m_thr[i]));
      end
    end
    if (upd_i < upd_cyc.size()) chk({tag, "_upd_cyc"}, 32'(upd_cyc[upd_i]), 32'(a + 2 + NB));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int ac, lat, a1, a2, u1, acks;
    logic [17:0] v;
    logic [5:0] ix;
    logic [31:0] exp;

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; count_done_i = 1'b0;
    for (int i = 0; i < 64; i++) scal_tab[i] = $urandom;
    model_reset();

    wait_cycles(3);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    chk("rst_outs", {25'd0, count_start_o, update_o, busy_o, 2'(thresh_ce_o), 2'd0}, 32'd0);
    chk("rst_thr", 32'(thresh_o), 32'd0);
    chk("rst_sidx", 32'(scal_idx_o), 32'd0);
    rst = 1'b0;

    xfer(1'b0, mk_adr(2'd0, 6'd0), 32'd0, rd, ac, lat);
    chk("ctrl_rst_rd", rd, 32'd0);
    chk("ctrl_lat", 32'(lat), 32'd1);
    xfer(1'b0, mk_adr(2'd1, 6'd0), 32'd0, rd, ac, lat);
    chk("thr0_rst_rd", rd, 32'(TI));

    xfer(1'b1, mk_adr(2'd1, 6'd1), 32'h0002ABCD, rd, ac, lat);
    m_thr[1] = 18'h2ABCD;
    chk("thr_wr_lat", 32'(lat), 32'd1);
    wait_cycles(1);
    chk("ack_one_pulse", 32'(wb_ack_o), 32'd0);
    chk("dat_idle", wb_dat_o, 32'd0);
    xfer(1'b0, mk_adr(2'd1, 6'd1), 32'd0, rd, ac, lat);
    chk("thr1_rd", rd, 32'h0002ABCD);

    clear_log();
    xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h1, rd, ac, lat);
    wait_cycles(1);
    chk("start_pulses", 32'(st_cyc.size()), 32'd1);
    if (st_cyc.size() > 0) chk("start_cyc", 32'(st_cyc[0]), 32'(ac));
    count_done_i = 1'b1; wait_cycles(1); count_done_i = 1'b0;
    m_fin = 1'b1;
    xfer(1'b0, mk_adr(2'd0, 6'd0), 32'd0, rd, ac, lat);
    chk("fin_set", rd, {31'd0, m_fin});
    count_done_i = 1'b1;
    xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h1, rd, ac, lat);
    count_done_i = 1'b0;
    m_fin = 1'b0;
    xfer(1'b0, mk_adr(2'd0, 6'd0), 32'd0, rd, ac, lat);
    chk("fin_start_wins", rd, {31'd0, m_fin});

    // Single apply sequence.
    clear_log();
    xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h2, rd, a1, lat);
    wait_cycles(NB + 6);
    chk("ap_ce_count", 32'(ce_cyc.size()), 32'(NB));
    chk("ap_upd_count", 32'(upd_cyc.size()), 32'd1);
    check_apply("ap", a1, 0, 0);
    chk("ap_busy_len", 32'(bz_cyc.size()), 32'(NB + 2));
    if (bz_cyc.size() > 0) chk("ap_busy_first", 32'(bz_cyc[0]), 32'(a1 + 1));
    xfer(1'b0, mk_adr(2'd0, 6'd0), 32'd0, rd, ac, lat);
    chk("ap_ctrl_idle", rd, {31'd0, m_fin});

    // Re-request during LOAD plus a stalled THRESH write.
    clear_log();
    xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h2, rd, a1, lat);
    xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h2, rd, a2, lat);
    check_apply("pd1", a1, 0, 0);
    v = 18'($urandom);
    xfer(1'b1, mk_adr(2'd1, 6'd0), {14'h3A5A, v}, rd, ac, lat);
    m_thr[0] = v;
    u1 = a1 + 2 + NB;
    chk("stall_after_upd", 32'(ac > u1), 32'd1);
    wait_cycles(NB + 10);
    chk("pd_ce_count", 32'(ce_cyc.size()), 32'(2 * NB));
    chk("pd_upd_count", 32'(upd_cyc.size()), 32'd2);
    check_apply("pd2", u1 + 1, NB, 1);

    // Scaler reads.
    scal_tab[1] = 32'hDEADBEEF;
    xfer(1'b0, mk_adr(2'd2, 6'd1), 32'd0, rd, ac, lat);
    chk("scal1_dat", rd, 32'hDEADBEEF);
    chk("scal1_lat", 32'(lat), 32'd2);
    xfer(1'b0, mk_adr(2'd2, 6'd50), 32'd0, rd, ac, lat);
    chk("scal50_dat", rd, 32'd0);
    chk("scal50_lat", 32'(lat), 32'd2);

    // Scaler read abandoned after one cycle must never ack.
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = mk_adr(2'd2, 6'd0);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    repeat (4) begin
      if (wb_ack_o) acks++;
      @(posedge clk); #1;
    end
    chk("abandon_no_ack", 32'(acks), 32'd0);

    for (int it = 0; it < 80; it++) begin
      ix = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 3)) : 6'($urandom);
      case ($urandom_range(0, 5))
        0: begin
          wdat = $urandom;
          xfer(1'b1, mk_adr(2'd1, ix), wdat, rd, ac, lat);
          if (ix < NB) m_thr[ix] = wdat[17:0];
          chk("rnd_thr_wr_lat", 32'(lat), 32'd1);
        end
        1: begin
          xfer(1'b0, mk_adr(2'd1, ix), 32'd0, rd, ac, lat);
          exp = (ix < NB) ? {14'd0, m_thr[ix]} : 32'd0;
          chk("rnd_thr_rd", rd, exp);
        end
        2: begin
          scal_tab[ix] = $urandom;
          xfer(1'b0, mk_adr(2'd2, ix), 32'd0, rd, ac, lat);
          exp = (ix < NB) ? scal_tab[ix] : 32'd0;
          chk("rnd_scal_rd", rd, exp);
          chk("rnd_scal_lat", 32'(lat), 32'd2);
        end
        3: begin
          xfer(1'b0, mk_adr(2'd0, 6'd0), 32'd0, rd, ac, lat);
          chk("rnd_ctrl_rd", rd, {31'd0, m_fin});
        end
        4: begin
          if ($urandom_range(0, 1) == 0) begin
            count_done_i = 1'b1; wait_cycles(1); count_done_i = 1'b0;
            m_fin = 1'b1;
          end else begin
            xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h1, rd, ac, lat);
            m_fin = 1'b0;
          end
        end
        default: begin
          xfer(1'b1, mk_adr(2'($urandom_range(2, 3)), ix), $urandom, rd, ac, lat);
          chk("rnd_ign_wr_lat", 32'(lat), 32'd1);
        end
      endcase
    end

    // Reset in the middle of LOAD aborts without an update pulse.
    xfer(1'b1, mk_adr(2'd0, 6'd0), 32'h2, rd, a1, lat);
    wait_cycles(2);
    clear_log();
    rst = 1'b1;
    wait_cycles(2);
    chk("rst_mid_ce", 32'(thresh_ce_o), 32'd0);
    rst = 1'b0;
    model_reset();
    wait_cycles(NB + 6);
    chk("rst_mid_no_upd", 32'(upd_cyc.size()), 32'd0);
    chk("rst_mid_busy", 32'(busy_o), 32'd0);
    xfer(1'b0, mk_adr(2'd1, 6'd1), 32'd0, rd, ac, lat);
    chk("rst_mid_thr1", rd, {14'd0, m_thr[1]});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
